// File: rtl/vuvmu_memreq_arb.sv
// vuvmu_memreq_arb
//   Arbitrates NLD load channels and one store port onto a single registered
//   dcache request port, and routes dcache load responses back to their
//   channel.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   prio_mode           0: store-first with anti-starvation, 1: round-robin ring
//   ld_val/ld_rdy       per-channel load handshake
//   ld_addr/ld_tag      per-channel load address / tag (slice i = channel i)
//   st_val/st_rdy       store handshake
//   st_addr/st_data/st_wmask  store payload
//   dcachereq_*         registered request to dcache (val/rdy handshake)
//   dcacheresp_*        dcache response (no backpressure)
//   resp_val/tag/data   load response, resp_val one-hot by channel
//   busy                output register valid or any requester pending
module vuvmu_memreq_arb #(
  parameter int NLD        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prio_mode,
  input  logic [NLD-1:0]       ld_val,
  output logic [NLD-1:0]       ld_rdy,
  input  logic [NLD-1:0][27:0] ld_addr,
  input  logic [NLD-1:0][7:0]  ld_tag,
  input  logic                 st_val,
  output logic                 st_rdy,
  input  logic [27:0]          st_addr,
  input  logic [127:0]         st_data,
  input  logic [15:0]          st_wmask,
  output logic [27:0]          dcachereq_addr,
  output logic [11:0]          dcachereq_tag,
  output logic [127:0]         dcachereq_data,
  output logic [15:0]          dcachereq_wmask,
  output logic [3:0]           dcachereq_op,
  output logic                 dcachereq_val,
  input  logic                 dcachereq_rdy,
  input  logic                 dcacheresp_val,
  input  logic [11:0]          dcacheresp_tag,
  input  logic [127:0]         dcacheresp_data,
  output logic [NLD-1:0]       resp_val,
  output logic [7:0]           resp_tag,
  output logic [127:0]         resp_data,
  output logic                 busy
);

  typedef struct packed {
    logic [27:0]  addr;
    logic [11:0]  tag;
    logic [127:0] data;
    logic [15:0]  wmask;
    logic [3:0]   op;
  } req_t;

  req_t         req_q, req_d;
  logic         req_vld;
  logic [1:0]   ld_ptr, ld_ptr_d;      // mode 0: next load channel to try first
  logic [2:0]   ring_ptr, ring_ptr_d;  // mode 1: next ring slot to try first
  logic [3:0]   starve_cnt;
  logic         any_ld, can_grant, starved;
  logic         ld_hit, ring_hit;
  logic [1:0]   ld_pick;
  logic [2:0]   ring_pick;
  logic [NLD:0] ring_req;
  logic         gnt_st, gnt_ld;
  logic [1:0]   gnt_ch;
  logic         unused_tag_bit;

  assign unused_tag_bit = dcacheresp_tag[8];

  // Grant decision. Round-robin is done as two priority passes with constant
  // indices: first the slots at/after the pointer, then the wrapped slots.
  always_comb begin
    any_ld    = |ld_val;
    can_grant = reset & (~req_vld | dcachereq_rdy);
    starved   = (starve_cnt == 4'(STARVE_MAX)) & any_ld;

    ld_hit  = 1'b0;
    ld_pick = '0;
    for (int c = 0; c < NLD; c++)
      if (!ld_hit && ld_val[c] && (2'(c) >= ld_ptr)) begin
        ld_hit  = 1'b1;
        ld_pick = 2'(c);
      end
    for (int c = 0; c < NLD; c++)
      if (!ld_hit && ld_val[c]) begin
        ld_hit  = 1'b1;
        ld_pick = 2'(c);
      end

    // store port is the last ring slot (index NLD)
    ring_req  = {st_val, ld_val};
    ring_hit  = 1'b0;
    ring_pick = '0;
    for (int c = 0; c <= NLD; c++)
      if (!ring_hit && ring_req[c] && (3'(c) >= ring_ptr)) begin
        ring_hit  = 1'b1;
        ring_pick = 3'(c);
      end
    for (int c = 0; c <= NLD; c++)
      if (!ring_hit && ring_req[c]) begin
        ring_hit  = 1'b1;
        ring_pick = 3'(c);
      end

    gnt_st = 1'b0;
    gnt_ld = 1'b0;
    gnt_ch = ld_pick;
    if (can_grant) begin
      if (prio_mode) begin
        if (ring_hit) begin
          if (ring_pick == 3'(NLD)) gnt_st = 1'b1;
          else begin
            gnt_ld = 1'b1;
            gnt_ch = ring_pick[1:0];
          end
        end
      end else if (st_val && !starved) begin
        gnt_st = 1'b1;
      end else if (ld_hit) begin
        gnt_ld = 1'b1;
      end
    end

    ld_ptr_d   = (ld_pick == 2'(NLD-1)) ? 2'd0 : ld_pick + 2'd1;
    ring_ptr_d = (ring_pick == 3'(NLD)) ? 3'd0 : ring_pick + 3'd1;
  end

  // Request payload and handshakes
  always_comb begin
    req_d  = '0;
    st_rdy = gnt_st;
    ld_rdy = '0;
    if (gnt_st) begin
      req_d.addr  = st_addr;
      req_d.tag   = 12'h800;
      req_d.data  = st_data;
      req_d.wmask = st_wmask;
      req_d.op    = 4'b0001;
    end
    for (int c = 0; c < NLD; c++)
      if (gnt_ld && (gnt_ch == 2'(c))) begin
        ld_rdy[c]  = 1'b1;
        req_d.addr = ld_addr[c];
        req_d.tag  = {1'b0, gnt_ch, 1'b0, ld_tag[c]};
      end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_vld    <= 1'b0;
      req_q      <= '0;
      ld_ptr     <= '0;
      ring_ptr   <= '0;
      starve_cnt <= '0;
    end else begin
      // a grant implies the register is empty or draining this cycle
      if (gnt_st | gnt_ld) begin
        req_vld <= 1'b1;
        req_q   <= req_d;
      end else if (dcachereq_rdy) begin
        req_vld <= 1'b0;
      end

      if (gnt_ld && !prio_mode)          ld_ptr   <= ld_ptr_d;
      if ((gnt_st | gnt_ld) && prio_mode) ring_ptr <= ring_ptr_d;

      if (!any_ld || gnt_ld)
        starve_cnt <= '0;
      else if (gnt_st && (starve_cnt != 4'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign dcachereq_val   = req_vld;
  assign dcachereq_addr  = req_q.addr;
  assign dcachereq_tag   = req_q.tag;
  assign dcachereq_data  = req_q.data;
  assign dcachereq_wmask = req_q.wmask;
  assign dcachereq_op    = req_q.op;

  assign busy = req_vld | (|ld_val) | st_val;

  // Response routing: store responses (tag[11]) and out-of-range channels
  // simply never match a lane.
  for (genvar c = 0; c < NLD; c++) begin : g_resp
    assign resp_val[c] = reset & dcacheresp_val & ~dcacheresp_tag[11] &
                         (dcacheresp_tag[10:9] == 2'(c));
  end
  assign resp_tag  = dcacheresp_tag[7:0];
  assign resp_data = dcacheresp_data;

endmodule

// File: tb/tb_vuvmu_memreq_arb.sv
// Bench for vuvmu_memreq_arb: a 2-channel instance for arbitration/response
// checks and a 1-channel instance for the ring wrap. Expected requests are
// queued when stimulus is driven and popped as the DUT hands them to dcache.
module tb_vuvmu_memreq_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic reset;
  logic prio_mode;
  logic [1:0] ld_val, ld_rdy;
  logic [1:0][27:0] ld_addr;
  logic [1:0][7:0] ld_tag;
  logic st_val, st_rdy;
  logic [27:0] st_addr;
  logic [127:0] st_data;
  logic [15:0] st_wmask;
  logic [27:0] dq_addr;
  logic [11:0] dq_tag;
  logic [127:0] dq_data;
  logic [15:0] dq_wmask;
  logic [3:0] dq_op;
  logic dq_val, dq_rdy;
  logic rs_val;
  logic [11:0] rs_tag;
  logic [127:0] rs_data;
  logic [1:0] resp_val;
  logic [7:0] resp_tag;
  logic [127:0] resp_data;
  logic busy;

  logic d1_prio;
  logic [0:0] d1_ld_val, d1_ld_rdy;
  logic [0:0][27:0] d1_ld_addr;
  logic [0:0][7:0] d1_ld_tag;
  logic d1_st_val, d1_st_rdy;
  logic [27:0] d1_st_addr;
  logic [127:0] d1_st_data;
  logic [15:0] d1_st_wmask;
  logic [27:0] d1_addr;
  logic [11:0] d1_tag;
  logic [127:0] d1_data;
  logic [15:0] d1_wmask;
  logic [3:0] d1_op;
  logic d1_val, d1_rdy;
  logic [0:0] d1_resp_val;
  logic [7:0] d1_resp_tag;
  logic [127:0] d1_resp_data;
  logic d1_busy;

  vuvmu_memreq_arb #(.NLD(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset), .prio_mode(prio_mode),
    .ld_val(ld_val), .ld_rdy(ld_rdy), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .st_val(st_val), .st_rdy(st_rdy), .st_addr(st_addr), .st_data(st_data),
    .st_wmask(st_wmask),
    .dcachereq_addr(dq_addr), .dcachereq_tag(dq_tag), .dcachereq_data(dq_data),
    .dcachereq_wmask(dq_wmask), .dcachereq_op(dq_op), .dcachereq_val(dq_val),
    .dcachereq_rdy(dq_rdy),
    .dcacheresp_val(rs_val), .dcacheresp_tag(rs_tag), .dcacheresp_data(rs_data),
    .resp_val(resp_val), .resp_tag(resp_tag), .resp_data(resp_data), .busy(busy)
  );

  vuvmu_memreq_arb #(.NLD(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset), .prio_mode(d1_prio),
    .ld_val(d1_ld_val), .ld_rdy(d1_ld_rdy), .ld_addr(d1_ld_addr), .ld_tag(d1_ld_tag),
    .st_val(d1_st_val), .st_rdy(d1_st_rdy), .st_addr(d1_st_addr), .st_data(d1_st_data),
    .st_wmask(d1_st_wmask),
    .dcachereq_addr(d1_addr), .dcachereq_tag(d1_tag), .dcachereq_data(d1_data),
    .dcachereq_wmask(d1_wmask), .dcachereq_op(d1_op), .dcachereq_val(d1_val),
    .dcachereq_rdy(d1_rdy),
    .dcacheresp_val(rs_val), .dcacheresp_tag(rs_tag), .dcacheresp_data(rs_data),
    .resp_val(d1_resp_val), .resp_tag(d1_resp_tag), .resp_data(d1_resp_data),
    .busy(d1_busy)
  );

  logic [191:0] q0[$];
  logic [191:0] q1[$];

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] pk(input logic [27:0] a, input logic [11:0] t,
                                      input logic [3:0] op, input logic [15:0] wm,
                                      input logic [127:0] d);
    return {4'b0, a, t, op, wm, d};
  endfunction

  task automatic push_st();
    q0.push_back(pk(st_addr, 12'h800, 4'b0001, st_wmask, st_data));
  endtask

  task automatic push_ld(input logic [1:0] c);
    q0.push_back(pk(ld_addr[c[0]], {1'b0, c, 1'b0, ld_tag[c[0]]}, 4'b0000, 16'h0, 128'h0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_val = 1'b0; ld_val = '0; d1_st_val = 1'b0; d1_ld_val = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Transfers happen on the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (reset && dq_val && dq_rdy) begin
      if (q0.size() == 0) chk("sb0_extra", pk(dq_addr, dq_tag, dq_op, dq_wmask, dq_data), 192'h0);
      else chk("sb0", pk(dq_addr, dq_tag, dq_op, dq_wmask, dq_data), q0.pop_front());
    end
    if (reset && d1_val && d1_rdy) begin
      if (q1.size() == 0) chk("sb1_extra", pk(d1_addr, d1_tag, d1_op, d1_wmask, d1_data), 192'h0);
      else chk("sb1", pk(d1_addr, d1_tag, d1_op, d1_wmask, d1_data), q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; prio_mode = 1'b0; ld_addr = '0; ld_tag = '0;
    st_addr = '0; st_data = '0; st_wmask = '0; dq_rdy = 1'b0;
    rs_tag = 12'h0A5; rs_data = '0; rs_val = 1'b1;
    d1_prio = 1'b0; d1_ld_val = '0; d1_ld_addr = '0; d1_ld_tag = '0;
    d1_st_val = 1'b0; d1_st_addr = '0; d1_st_data = '0; d1_st_wmask = '0; d1_rdy = 1'b0;
    st_val = 1'b1; ld_val = 2'b11;

    // reset state, with requesters pending
    tick();
    chk("rst_dq_val", 192'(dq_val), 192'(0));
    chk("rst_rdy", 192'({st_rdy, ld_rdy}), 192'(0));
    chk("rst_busy_follow", 192'(busy), 192'(1));
    chk("rst_resp_val", 192'(resp_val), 192'(0));
    chk("rst_fields", 192'({dq_addr, dq_tag, dq_op, dq_wmask, dq_data}), 192'(0));
    idle(); rs_val = 1'b0;
    #1;
    chk("rst_busy_idle", 192'(busy), 192'(0));
    tick();
    reset = 1'b1;

    // mode 0 starvation pattern: 4 stores, 1 load
    prio_mode = 1'b0; dq_rdy = 1'b1; ld_tag[0] = 8'h3C;
    for (int i = 0; i < 15; i++) begin
      st_addr = 28'h100 + 28'(i); st_data = {4{32'(i) ^ 32'hA5A5_0000}};
      st_wmask = 16'hF0F0 ^ 16'(i); ld_addr[0] = 28'h200 + 28'(i);
      st_val = 1'b1; ld_val = 2'b01;
      #1;
      if (i % 5 == 4) begin
        push_ld(2'd0);
        chk("m0_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b001));
      end else begin
        push_st();
        chk("m0_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100));
      end
      tick();
    end
    idle(); tick(); tick();
    chk("m0_drain", 192'(q0.size()), 192'(0));

    // mode 1 ring: ld0, ld1, st, ...
    do_reset();
    prio_mode = 1'b1; ld_tag[0] = 8'h4A; ld_tag[1] = 8'h5B;
    for (int i = 0; i < 9; i++) begin
      st_addr = 28'h400 + 28'(i); st_data = {4{32'(i) + 32'h1000}}; st_wmask = 16'(i) + 16'h0101;
      ld_addr[0] = 28'h500 + 28'(i); ld_addr[1] = 28'h600 + 28'(i);
      st_val = 1'b1; ld_val = 2'b11;
      #1;
      case (i % 3)
        0: begin push_ld(2'd0); chk("m1_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b001)); end
        1: begin push_ld(2'd1); chk("m1_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b010)); end
        default: begin push_st(); chk("m1_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100)); end
      endcase
      tick();
    end
    idle(); tick(); tick();
    chk("m1_drain", 192'(q0.size()), 192'(0));

    // backpressure: register holds, no grants, then same-cycle grant
    do_reset();
    prio_mode = 1'b0; dq_rdy = 1'b0;
    st_addr = 28'hAAA0; st_data = {4{32'hCAFE_0001}}; st_wmask = 16'h00FF; st_val = 1'b1;
    #1;
    chk("bp_first_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100));
    push_st();
    tick();
    st_addr = 28'hBBB0; st_data = {4{32'hBEEF_0002}}; st_wmask = 16'hFF00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold", 192'({dq_val, dq_addr, dq_tag, dq_op, dq_wmask}),
          192'({1'b1, 28'hAAA0, 12'h800, 4'b0001, 16'h00FF}));
      chk("bp_hold_data", 192'(dq_data), 192'({4{32'hCAFE_0001}}));
      chk("bp_rdy", 192'({st_rdy, ld_rdy}), 192'(0));
      tick();
    end
    dq_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100));
    push_st();
    tick();
    chk("bp_next_addr", 192'(dq_addr), 192'(28'hBBB0));
    idle(); tick(); tick();
    chk("bp_drain", 192'(q0.size()), 192'(0));

    // response routing
    rs_val = 1'b1; rs_tag = 12'h2A5; rs_data = {4{32'h1234_5678}};
    #1;
    chk("rsp_ch1_val", 192'(resp_val), 192'(2'b10));
    chk("rsp_ch1_tag", 192'(resp_tag), 192'(8'hA5));
    chk("rsp_ch1_data", 192'(resp_data), 192'({4{32'h1234_5678}}));
    chk("rsp_nld1_drop", 192'(d1_resp_val), 192'(0));
    rs_tag = 12'h03C;
    #1;
    chk("rsp_ch0_val", 192'(resp_val), 192'(2'b01));
    chk("rsp_nld1_ch0", 192'(d1_resp_val), 192'(1));
    rs_tag = 12'h800;
    #1;
    chk("rsp_store_drop", 192'(resp_val), 192'(0));
    rs_val = 1'b0; rs_tag = 12'h0A5;
    #1;
    chk("rsp_noval", 192'(resp_val), 192'(0));

    // reset with a held request; starve count must restart from 0
    do_reset();
    prio_mode = 1'b0; dq_rdy = 1'b1; ld_tag[0] = 8'h11; ld_addr[0] = 28'h700;
    for (int i = 0; i < 3; i++) begin
      st_addr = 28'h800 + 28'(i); st_data = {4{32'(i) + 32'h77}}; st_wmask = 16'(i) + 16'h3;
      st_val = 1'b1; ld_val = 2'b01;
      #1;
      chk("rr_pre_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100));
      if (i < 2) push_st();
      tick();
    end
    dq_rdy = 1'b0; st_addr = 28'h8FF;
    #1;
    reset = 1'b0;
    #1;
    chk("rr_val_drop", 192'(dq_val), 192'(0));
    chk("rr_rdy_zero", 192'({st_rdy, ld_rdy}), 192'(0));
    chk("rr_busy_follow", 192'(busy), 192'(1));
    tick();
    reset = 1'b1; dq_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st_addr = 28'h900 + 28'(i); st_data = {4{32'(i) + 32'h9}}; st_wmask = 16'(i) + 16'h9;
      ld_addr[0] = 28'hA00 + 28'(i);
      st_val = 1'b1; ld_val = 2'b01;
      #1;
      if (i % 5 == 4) begin
        push_ld(2'd0);
        chk("rr_post_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b001));
      end else begin
        push_st();
        chk("rr_post_rdy", 192'({st_rdy, ld_rdy}), 192'(3'b100));
      end
      tick();
    end
    idle(); tick(); tick();
    chk("rr_drain", 192'(q0.size()), 192'(0));

    // NLD=1 ring: load every cycle, then wrap with the store slot
    do_reset();
    d1_prio = 1'b1; d1_rdy = 1'b1; d1_ld_tag[0] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      d1_ld_addr[0] = 28'hC00 + 28'(i);
      d1_st_addr = 28'hD00 + 28'(i); d1_st_data = {4{32'(i) + 32'h5}}; d1_st_wmask = 16'(i) + 16'h5;
      d1_ld_val = 1'b1;
      d1_st_val = (i >= 4);
      #1;
      if (i >= 4 && i % 2 == 0) begin
        q1.push_back(pk(d1_st_addr, 12'h800, 4'b0001, d1_st_wmask, d1_st_data));
        chk("n1_rdy", 192'({d1_st_rdy, d1_ld_rdy}), 192'(2'b10));
      end else begin
        q1.push_back(pk(d1_ld_addr[0], 12'h077, 4'b0000, 16'h0, 128'h0));
        chk("n1_rdy", 192'({d1_st_rdy, d1_ld_rdy}), 192'(2'b01));
      end
      tick();
    end
    idle(); tick(); tick();
    chk("n1_drain", 192'(q1.size()), 192'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vuvmu_memreq_arb.md
VUVMU_MEMREQ_ARB -- requirements
Module: vuvmu_memreq_arb

Interface
REQ-001 SHALL have parameter NLD, default 2, number of load-request channels (legal 1..4).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive store grants allowed while a load waits (legal 1..15).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port prio_mode, input, 1: 0 = store-first with anti-starvation, 1 = round-robin over stores and loads.
REQ-006 SHALL have ports ld_val (input, NLD), ld_rdy (output, NLD), ld_addr (input, NLD*28) and ld_tag (input, NLD*8): per-channel load requests; channel i occupies slice i.
REQ-007 SHALL have ports st_val (input, 1), st_rdy (output, 1), st_addr (input, 28), st_data (input, 128) and st_wmask (input, 16): store requests.
REQ-008 SHALL have ports dcachereq_addr (output, 28), dcachereq_tag (output, 12), dcachereq_data (output, 128), dcachereq_wmask (output, 16), dcachereq_op (output, 4), dcachereq_val (output, 1) and dcachereq_rdy (input, 1).
REQ-009 SHALL have ports dcacheresp_val (input, 1), dcacheresp_tag (input, 12) and dcacheresp_data (input, 128).
REQ-010 SHALL have ports resp_val (output, NLD), resp_tag (output, 8) and resp_data (output, 128): load responses routed to their channel.
REQ-011 SHALL have port busy, output, 1: high when the output register is valid or any ld_val/st_val is high.

Function
REQ-012 SHALL hold one output register (addr, tag, data, wmask, op, valid); dcachereq_* SHALL be driven directly from it.
REQ-013 SHALL make a grant when the register is empty, or when it is full and dcachereq_rdy=1 in the same cycle (full-throughput, 1 request per cycle).
REQ-014 SHALL assert exactly one of st_rdy/ld_rdy[i] in a cycle, only for the granted valid requester; all rdy outputs SHALL be 0 when no grant can be made.
REQ-015 SHALL use 1-cycle latency: a request accepted in cycle N appears on dcachereq_* in cycle N+1.
REQ-016 SHALL, in mode 0, grant a pending store first, unless starve_cnt==STARVE_MAX and some ld_val is high; in that case it SHALL grant a load.
REQ-017 SHALL, in mode 0, pick among loads by round-robin starting after the last-granted load channel.
REQ-018 SHALL keep starve_cnt (4 bits): increment on a store grant while any ld_val is high; clear on any load grant or when no ld_val is high; saturate at STARVE_MAX.
REQ-019 SHALL, in mode 1, treat the store port as requester index NLD in one round-robin ring of NLD+1 entries; the rr pointer SHALL advance to the slot after the granted slot, wrapping NLD to 0.
REQ-020 SHALL apply a prio_mode change at the next grant decision without clearing the pointer or starve_cnt.
REQ-021 SHALL drive store outputs as: tag=12'h800, op=4'b0001, data/wmask from st_*.
REQ-022 SHALL drive load outputs as: tag={1'b0, chan[1:0], 1'b0, ld_tag[7:0]}, op=4'b0000, data=0, wmask=0.
REQ-023 SHALL, combinationally, assert resp_val[tag[10:9]] when dcacheresp_val=1 and dcacheresp_tag[11]=0, with resp_tag=tag[7:0] and resp_data=dcacheresp_data; this path has no backpressure.
REQ-024 SHALL drop responses with tag[11]=1 (stores) and responses with a channel index >= NLD; resp_val SHALL stay 0 for them.
REQ-025 SHALL hold the output register stable while dcachereq_val=1 and dcachereq_rdy=0.

Reset
REQ-026 SHALL, while reset=0, force: output valid=0, dcachereq_val=0, all rdy=0, starve_cnt=0, rr pointers=0, resp_val=0, busy=0 (busy SHALL also follow ld_val/st_val); all other dcachereq_* fields SHALL be 0.
REQ-027 SHALL, on reset asserted mid-transfer, discard the held request without issuing it; the first grant after release SHALL occur on the first clk edge with reset=1.

Verification
REQ-028 Bench: NLD=2, mode 0, st_val and ld_val[0] held high, dcachereq_rdy=1 -> 4 stores, 1 load, 4 stores (pattern repeats); dcachereq_tag of each load = 12'h0xx with bits[10:9]=0.
REQ-029 Bench: mode 1, st_val and ld_val=2'b11 held high -> grant order ld0, ld1, st, ld0 …; one request per cycle.
REQ-030 Bench: dcachereq_rdy=0 for 3 cycles with the register full -> dcachereq_* unchanged and all rdy=0; rdy=1 -> next grant in the same cycle.
REQ-031 Bench: dcacheresp tag 12'h2A5 -> resp_val=2'b10, resp_tag=8'hA5; tag 12'h800 -> resp_val=0.
REQ-032 Bench: reset=0 asserted with the register full and dcachereq_rdy=0 -> dcachereq_val=0 immediately; after release, held requesters are re-granted with starve_cnt=0.
REQ-033 Bench: NLD=1, mode 1, only ld_val[0] high -> granted every cycle; pointer wrap 1 to 0 verified.
